dof_stage: RTL and testbench
============================

# dof_stage

Parametrised decode/operand-fetch pipeline stage for the RISC core, sitting between instruction fetch and execute. It registers the fetched instruction and PC, decodes the instruction into a control word, and reads operands through the register-file ports. It selects constant and PC operands, detects read-after-write hazards against the execute stage, and either forwards or stalls. All flops are on the rising edge; it presents a registered control/operand bundle to execute with a valid flag and bubble insertion.

## Interface
- XLEN, 32: datapath width (BUS_A, BUS_B, PC, forwarded data)
- RAW, 5: register address width (AA, BA, DA, SH)
- IMW, 15: immediate field width, IR[IMW-1:0]
- CLOCK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-low reset
- if_valid  in  1  IF presents an instruction
- PC_M1  in  XLEN  PC+1 of the presented instruction
- IR  in  32  presented instruction
- dof_ready  out  1  stage accepts IF this cycle (0 = stall IF)
- flush  in  1  taken branch/jump in EX; kill D and E contents
- AA, BA  out  RAW  register-file read addresses (combinational from D register)
- A_DATA, B_DATA  in  XLEN  register-file read data (asynchronous, write-first)
- ex_rw, ex_md[1:0], ex_da[RAW-1:0]  in  current EX-stage RW, MD, DA (qualified by ex_valid)
- ex_result  in  XLEN  EX-stage ALU/shift result (forwarding source)
- ex_valid  out  1  E register holds a real instruction
- BUS_A, BUS_B  out  XLEN  registered operands
- RW, MW, PS  out  1 each; DA, FS, SH  out  RAW/5/RAW; MD, BS  out  2 each: registered control word
- PC_M2  out  XLEN  registered PC+1 of the instruction in E

## Operation
- Fields: opcode IR[31:25], DA IR[24:20], AA IR[19:15], BA IR[14:10], IM IR[IMW-1:0], SH IR[4:0].
- D register {d_valid, d_pc, d_ir} loads on if_valid && dof_ready. It holds when dof_ready=0 and clears d_valid when IF is idle.
- Decoder yields RW, DA, MD, BS, PS, MW, FS, MA, MB, CS. Constant: CS=1 sign-extends IM to XLEN, CS=0 zero-fills it.
- BUS_A = MA ? d_pc : opA; BUS_B = MB ? const : opB. opA/opB are A_DATA/B_DATA or the forwarded value.
- Hazard on A: d_valid && ex_valid && ex_rw && ex_da!=0 && ex_da==AA && MA==0. B is the same with BA/MB. R0 never hazards.
- Load hazard (ex_md==01) always stalls one cycle.
- Non-load hazards are resolved per the Configuration section.
- Stall: dof_ready=0, D holds, E loads a bubble.
- Bubble or flush: ex_valid=0 and RW=MW=PS=0, BS=00. Data fields are don't-care but driven 0.
- flush: d_valid and ex_valid both clear at the next edge, and the IF instruction in that cycle is discarded. flush beats stall.
- Reset (RESET=0 at edge): every registered output and d_valid/d_pc/d_ir go to 0. dof_ready is 1 after reset.

## Timing
- Latency 1: instruction accepted at edge k appears on E outputs after edge k+1, with no stall.
- Load-use: exactly one bubble, then the instruction issues with A_DATA/B_DATA, since the register file is write-first from WB.
- dof_ready, AA and BA are combinational from the D register and EX inputs. There is no path from if_valid to dof_ready.
- Throughput is 1 instruction/cycle absent hazards and flush.
- Reset asserted mid-stall abandons the stall, and the next post-reset cycle accepts.

## Configuration
- DOF_FWD_EN defined: a non-load EX hazard forwards ex_result into opA/opB with no stall.
- DOF_FWD_EN undefined: every EX hazard stalls one cycle, and the ex_result input is unused.

## Structure
- Shared package risc_pkg: field offsets, opcode constants (ADD 7'h02, ST 7'h03, LD 7'h21, ADI 7'h22, ...), MD/BS encodings, control-word struct, and the decoder truth table.
- One sub-module: dof_decoder (pure combinational, d_ir → control word). Hazard, forwarding, muxing and registers stay in dof_stage.

## Test plan
- Reset: RESET=0 for 2 cycles with if_valid=1 → ex_valid=0, all outputs 0, dof_ready=1.
- ADI R1,R2,#0x7FFF (CS=0) with A_DATA=5 → one cycle later BUS_A=5, BUS_B=0x00007FFF, DA=1, RW=1, ex_valid=1.
- LD R3 then ADD R4,R3,R5 → dof_ready=0 for one cycle, one bubble (ex_valid=0, RW=0), then ADD issues with BUS_A=A_DATA.
- ADD R6,R1,R2 in EX with ex_result=0x1234, then ADD R7,R6,R6 → with DOF_FWD_EN, BUS_A=BUS_B=0x1234 and no stall; without it, one bubble.
- flush=1 while D holds a valid instruction and dof_ready=0 → next cycle ex_valid=0, d_valid=0, dof_ready=1.
- EX writes R0 (ex_da=0) and decode reads R0 → no stall, no forward, BUS_A=A_DATA.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg -- shared definitions for the RISC core's decode/operand-fetch stage.
//
// Contents:
//   - Instruction field offsets (opcode, DA, AA, BA, SH) for the 32-bit IR.
//   - Opcode constants, MD (write-back source) and BS (branch select) encodings.
//   - ctrl_t: the control word produced by the decoder.
//   - decode_op(): the decoder truth table, opcode -> control word.
//     Unknown opcodes decode as a NOP (no register write, no memory write, no branch).
package risc_pkg;

  localparam int unsigned IR_W   = 32;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned FS_W   = 5;
  localparam int unsigned OP_LSB = 25;
  localparam int unsigned DA_LSB = 20;
  localparam int unsigned AA_LSB = 15;
  localparam int unsigned BA_LSB = 10;
  localparam int unsigned SH_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 7'h00,
    OP_ADD = 7'h02,
    OP_ST  = 7'h03,
    OP_SUB = 7'h05,
    OP_JML = 7'h07,
    OP_SLL = 7'h0E,
    OP_LD  = 7'h21,
    OP_ADI = 7'h22,
    OP_SUI = 7'h25,
    OP_JMP = 7'h44,
    OP_BRZ = 7'h60,
    OP_BRN = 7'h61
  } opcode_e;

  // Write-back source select.
  typedef enum logic [1:0] {
    MD_FU  = 2'b00,
    MD_MEM = 2'b01,
    MD_PC  = 2'b10
  } md_e;

  // Branch select.
  typedef enum logic [1:0] {
    BS_NONE = 2'b00,
    BS_COND = 2'b01,
    BS_JUMP = 2'b10,
    BS_JREG = 2'b11
  } bs_e;

  localparam logic [FS_W-1:0] FS_PASS = 5'b00000;
  localparam logic [FS_W-1:0] FS_ADD  = 5'b00010;
  localparam logic [FS_W-1:0] FS_SUB  = 5'b00101;
  localparam logic [FS_W-1:0] FS_LINK = 5'b00111;
  localparam logic [FS_W-1:0] FS_SLL  = 5'b10100;

  typedef struct packed {
    logic            rw;  // register write
    md_e             md;  // write-back source
    bs_e             bs;  // branch select
    logic            ps;  // branch polarity
    logic            mw;  // memory write
    logic [FS_W-1:0] fs;  // function select
    logic            ma;  // BUS_A takes PC instead of register A
    logic            mb;  // BUS_B takes the constant instead of register B
    logic            cs;  // constant is sign-extended
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t decode_op(input logic [OP_W-1:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_ADD: begin c.rw = 1'b1; c.fs = FS_ADD; end
      OP_ST:  begin c.mw = 1'b1; end
      OP_SUB: begin c.rw = 1'b1; c.fs = FS_SUB; end
      OP_JML: begin
        c.rw = 1'b1; c.md = MD_PC; c.bs = BS_JUMP; c.fs = FS_LINK;
        c.ma = 1'b1; c.mb = 1'b1; c.cs = 1'b1;
      end
      OP_SLL: begin c.rw = 1'b1; c.fs = FS_SLL; end
      OP_LD:  begin c.rw = 1'b1; c.md = MD_MEM; end
      OP_ADI: begin c.rw = 1'b1; c.fs = FS_ADD; c.mb = 1'b1; end
      OP_SUI: begin c.rw = 1'b1; c.fs = FS_SUB; c.mb = 1'b1; c.cs = 1'b1; end
      OP_JMP: begin c.bs = BS_JREG; c.mb = 1'b1; c.cs = 1'b1; end
      OP_BRZ: begin c.bs = BS_COND; c.mb = 1'b1; c.cs = 1'b1; end
      OP_BRN: begin c.bs = BS_COND; c.ps = 1'b1; c.mb = 1'b1; c.cs = 1'b1; end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dof_decoder.sv
// dof_decoder -- purely combinational instruction decoder for dof_stage.
//
// Ports:
//   opcode  in   7   opcode field of the instruction held in the D register
//   ctrl    out  ctrl_t  decoded control word (RW, MD, BS, PS, MW, FS, MA, MB, CS)
// Register addresses and immediates are plain IR fields and are sliced by the stage.
module dof_decoder
  import risc_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl
);

  always_comb begin
    ctrl = decode_op(opcode);
  end

endmodule

// File: rtl/dof_stage.sv
// dof_stage -- decode / operand-fetch pipeline stage between IF and EX.
//
// Holds the fetched instruction in a D register, decodes it, reads the register
// file through AA/BA, builds the BUS_A/BUS_B operands and presents a registered
// control/operand bundle (the E register) to execute.
//
// Build option: define DOF_FWD_EN to forward ex_result on non-load EX hazards;
// without it every EX hazard stalls one cycle and ex_result is ignored.
//
// Ports:
//   CLOCK, RESET            rising-edge clock, synchronous active-low reset
//   if_valid, PC_M1, IR     instruction presented by IF
//   dof_ready               stage accepts IF this cycle (0 = stall)
//   flush                   kill D and E contents (taken branch/jump in EX)
//   AA, BA / A_DATA, B_DATA register-file read addresses / asynchronous read data
//   ex_rw, ex_md, ex_da     control of the instruction now in EX
//   ex_result               EX result, forwarding source
//   ex_valid                E register holds a real instruction
//   BUS_A, BUS_B            registered operands
//   RW, MW, PS, DA, FS, SH, MD, BS   registered control word
//   PC_M2                   registered PC+1 of the instruction in E
module dof_stage
  import risc_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5,
  parameter int unsigned IMW  = 15
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            if_valid,
  input  logic [XLEN-1:0] PC_M1,
  input  logic [31:0]     IR,
  output logic            dof_ready,
  input  logic            flush,
  output logic [RAW-1:0]  AA,
  output logic [RAW-1:0]  BA,
  input  logic [XLEN-1:0] A_DATA,
  input  logic [XLEN-1:0] B_DATA,
  input  logic            ex_rw,
  input  logic [1:0]      ex_md,
  input  logic [RAW-1:0]  ex_da,
  input  logic [XLEN-1:0] ex_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] BUS_A,
  output logic [XLEN-1:0] BUS_B,
  output logic            RW,
  output logic            MW,
  output logic            PS,
  output logic [RAW-1:0]  DA,
  output logic [4:0]      FS,
  output logic [RAW-1:0]  SH,
  output logic [1:0]      MD,
  output logic [1:0]      BS,
  output logic [XLEN-1:0] PC_M2
);

  logic            d_valid;
  logic [XLEN-1:0] d_pc;
  logic [IR_W-1:0] d_ir;

  ctrl_t           ctrl;
  logic [XLEN-1:0] const_val;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            haz_a;
  logic            haz_b;
  logic            ex_load;
  logic            stall;
  logic            bubble;

  dof_decoder u_decoder (
    .opcode (d_ir[OP_LSB +: OP_W]),
    .ctrl   (ctrl)
  );

  assign AA = d_ir[AA_LSB +: RAW];
  assign BA = d_ir[BA_LSB +: RAW];

  always_comb begin
    // NOTE: give every always_comb output a default before any condition so no path leaves it unassigned (which would infer a latch).
    const_val          = '0;
    const_val[IMW-1:0] = d_ir[IMW-1:0];
    if (ctrl.cs) begin
      const_val[XLEN-1:IMW] = {(XLEN-IMW){d_ir[IMW-1]}};
    end
  end

  // A port that is overridden by PC (MA) or the constant (MB) cannot hazard,
  // and R0 is hard-wired to zero so writes to it never create a dependency.
  assign haz_a   = d_valid && ex_valid && ex_rw && (ex_da != '0) && (ex_da == AA) && !ctrl.ma;
  assign haz_b   = d_valid && ex_valid && ex_rw && (ex_da != '0) && (ex_da == BA) && !ctrl.mb;
  assign ex_load = (ex_md == MD_MEM);

`ifdef DOF_FWD_EN
  // Load data is not available until after EX, so only a load hazard stalls.
  // While stalling the bundle is discarded, so op_a/op_b need no load qualifier.
  assign stall = (haz_a || haz_b) && ex_load;
  assign op_a  = haz_a ? ex_result : A_DATA;
  assign op_b  = haz_b ? ex_result : B_DATA;
`else
  logic unused_ex_result;
  assign unused_ex_result = ^ex_result;
  // ex_load is implied: any hazard stalls, loads included.
  logic unused_ex_load;
  assign unused_ex_load = ex_load;
  assign stall = haz_a || haz_b;
  assign op_a  = A_DATA;
  assign op_b  = B_DATA;
`endif

  assign dof_ready = !stall;
  assign bubble    = flush || stall || !d_valid;

  // D register: holds during a stall, empties when IF is idle or on flush.
  always_ff @(posedge CLOCK) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together from pre-edge values.
    if (!RESET) begin
      d_valid <= 1'b0;
      d_pc    <= '0;
      d_ir    <= '0;
    end else if (flush) begin
      d_valid <= 1'b0;
    end else if (!stall) begin
      d_valid <= if_valid;
      if (if_valid) begin
        d_pc <= PC_M1;
        d_ir <= IR;
      end
    end
  end

  // E register: a bubble clears the whole bundle, not just ex_valid, so that
  // downstream never sees stale write enables or branch requests.
  always_ff @(posedge CLOCK) begin
    if (!RESET || bubble) begin
      ex_valid <= 1'b0;
      BUS_A    <= '0;
      BUS_B    <= '0;
      RW       <= 1'b0;
      MW       <= 1'b0;
      PS       <= 1'b0;
      DA       <= '0;
      FS       <= '0;
      SH       <= '0;
      MD       <= '0;
      BS       <= '0;
      PC_M2    <= '0;
    end else begin
      ex_valid <= 1'b1;
      BUS_A    <= ctrl.ma ? d_pc : op_a;
      BUS_B    <= ctrl.mb ? const_val : op_b;
      RW       <= ctrl.rw;
      MW       <= ctrl.mw;
      PS       <= ctrl.ps;
      DA       <= d_ir[DA_LSB +: RAW];
      FS       <= ctrl.fs;
      SH       <= d_ir[SH_LSB +: RAW];
      MD       <= ctrl.md;
      BS       <= ctrl.bs;
      PC_M2    <= d_pc;
    end
  end

endmodule

// File: tb/tb_dof_stage.sv
// tb_dof_stage -- scoreboard bench for dof_stage.
//
// The EX-side inputs are looped back from the stage's own E outputs, so the
// "instruction in EX" is always the previously issued one. ex_result is derived
// from PC_M2 with a fixed key so the expected forwarded value is known per
// instruction. The register file is a fixed table indexed by AA/BA.
// A transaction-level model (instruction slots in D and E) predicts dof_ready
// every cycle and pushes each expected issued bundle into a queue; a monitor on
// the falling edge pops and compares whenever ex_valid is high, and checks that
// bubbles present an all-zero bundle.
module tb_dof_stage;

  localparam logic [31:0] FWD_KEY = 32'hA5A5_0000;
`ifdef DOF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        if_valid;
  logic [31:0] PC_M1;
  logic [31:0] IR;
  logic        dof_ready;
  logic        flush;
  logic [4:0]  AA, BA;
  logic [31:0] A_DATA, B_DATA;
  logic        ex_rw;
  logic [1:0]  ex_md;
  logic [4:0]  ex_da;
  logic [31:0] ex_result;
  logic        ex_valid;
  logic [31:0] BUS_A, BUS_B;
  logic        RW, MW, PS;
  logic [4:0]  DA, FS, SH;
  logic [1:0]  MD, BS;
  logic [31:0] PC_M2;

  logic [31:0] rf_mem [32];

  assign A_DATA    = rf_mem[AA];
  assign B_DATA    = rf_mem[BA];
  assign ex_rw     = RW;
  assign ex_md     = MD;
  assign ex_da     = DA;
  assign ex_result = PC_M2 ^ FWD_KEY;

  always #5 CLOCK = ~CLOCK;

  dof_stage #(.XLEN(32), .RAW(5), .IMW(15)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .if_valid  (if_valid),
    .PC_M1     (PC_M1),
    .IR        (IR),
    .dof_ready (dof_ready),
    .flush     (flush),
    .AA        (AA),
    .BA        (BA),
    .A_DATA    (A_DATA),
    .B_DATA    (B_DATA),
    .ex_rw     (ex_rw),
    .ex_md     (ex_md),
    .ex_da     (ex_da),
    .ex_result (ex_result),
    .ex_valid  (ex_valid),
    .BUS_A     (BUS_A),
    .BUS_B     (BUS_B),
    .RW        (RW),
    .MW        (MW),
    .PS        (PS),
    .DA        (DA),
    .FS        (FS),
    .SH        (SH),
    .MD        (MD),
    .BS        (BS),
    .PC_M2     (PC_M2)
  );

  typedef struct packed {
    logic       rw;
    logic [1:0] md;
    logic [1:0] bs;
    logic       ps;
    logic       mw;
    logic [4:0] fs;
    logic       ma;
    logic       mb;
    logic       cs;
  } dec_t;

  typedef struct packed {
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic        rw;
    logic        mw;
    logic        ps;
    logic [4:0]  da;
    logic [4:0]  fs;
    logic [4:0]  sh;
    logic [1:0]  md;
    logic [1:0]  bs;
    logic [31:0] pc;
  } bundle_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ir;
  } slot_t;

  int      n_tests = 0;
  int      n_fail  = 0;
  bundle_t exp_q[$];
  slot_t   m_d, m_e;
  logic [31:0] pc_next;
  logic    mon_en = 1'b0;
  bundle_t obs;

  // Decoder table as a flat {rw,md,bs,ps,mw,fs,ma,mb,cs} word per opcode.
  function automatic dec_t tb_decode(input logic [6:0] op);
    dec_t c;
    case (op)
      7'h02:   c = 15'b1_00_00_0_0_00010_0_0_0;  // ADD
      7'h03:   c = 15'b0_00_00_0_1_00000_0_0_0;  // ST
      7'h05:   c = 15'b1_00_00_0_0_00101_0_0_0;  // SUB
      7'h07:   c = 15'b1_10_10_0_0_00111_1_1_1;  // JML
      7'h0E:   c = 15'b1_00_00_0_0_10100_0_0_0;  // SLL
      7'h21:   c = 15'b1_01_00_0_0_00000_0_0_0;  // LD
      7'h22:   c = 15'b1_00_00_0_0_00010_0_1_0;  // ADI
      7'h25:   c = 15'b1_00_00_0_0_00101_0_1_1;  // SUI
      7'h44:   c = 15'b0_00_11_0_0_00000_0_1_1;  // JMP
      7'h60:   c = 15'b0_00_01_0_0_00000_0_1_1;  // BRZ
      7'h61:   c = 15'b0_00_01_1_0_00000_0_1_1;  // BRN
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [4:0] da,
                                        input logic [4:0] aa, input logic [14:0] im);
    return {op, da, aa, im};
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    logic [6:0]  op;
    int          sel;
    r   = $urandom;
    sel = int'($urandom_range(0, 11));
    case (sel)
      0: op = 7'h02;  1: op = 7'h03;  2: op = 7'h05;  3: op = 7'h07;
      4: op = 7'h0E;  5: op = 7'h21;  6: op = 7'h22;  7: op = 7'h25;
      8: op = 7'h44;  9: op = 7'h60; 10: op = 7'h61;
      default: op = 7'h00;
    endcase
    r[31:25] = op;
    r[24:20] = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[14:10] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  // Bit 0: A operand depends on the E instruction; bit 1: B operand does.
  function automatic logic [1:0] deps(input slot_t d, input slot_t e);
    dec_t       cd, ce;
    logic [4:0] w;
    logic       live;
    logic [1:0] r;
    cd   = tb_decode(d.ir[31:25]);
    ce   = tb_decode(e.ir[31:25]);
    w    = e.ir[24:20];
    live = d.v && e.v && ce.rw && (w != 5'd0);
    r[0] = live && !cd.ma && (w == d.ir[19:15]);
    r[1] = live && !cd.mb && (w == d.ir[14:10]);
    return r;
  endfunction

  function automatic logic must_stall(input slot_t d, input slot_t e);
    logic is_load;
    is_load = (tb_decode(e.ir[31:25]).md == 2'b01);
    return (|deps(d, e)) && (is_load || !FWD);
  endfunction

  // Expected E bundle for instruction d issuing while e sits in EX.
  function automatic bundle_t expect_issue(input slot_t d, input slot_t e);
    dec_t        cd;
    logic [1:0]  h;
    logic [31:0] k;
    bundle_t     b;
    cd = tb_decode(d.ir[31:25]);
    h  = deps(d, e);
    k  = cd.cs ? {{17{d.ir[14]}}, d.ir[14:0]} : {17'd0, d.ir[14:0]};
    b.bus_a = cd.ma ? d.pc : (h[0] ? (e.pc ^ FWD_KEY) : rf_mem[d.ir[19:15]]);
    b.bus_b = cd.mb ? k    : (h[1] ? (e.pc ^ FWD_KEY) : rf_mem[d.ir[14:10]]);
    b.rw = cd.rw;
    b.mw = cd.mw;
    b.ps = cd.ps;
    b.da = d.ir[24:20];
    b.fs = cd.fs;
    b.sh = d.ir[4:0];
    b.md = cd.md;
    b.bs = cd.bs;
    b.pc = d.pc;
    return b;
  endfunction

  function automatic bundle_t observed();
    bundle_t b;
    b = {BUS_A, BUS_B, RW, MW, PS, DA, FS, SH, MD, BS, PC_M2};
    return b;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle of IF/flush/reset stimulus plus the model update for the coming edge.
  task automatic step(input logic v, input logic [31:0] ir, input logic fl,
                      input logic rst, output logic accepted);
    logic stall_exp;
    @(posedge CLOCK);
    #1;
    if_valid = v;
    IR       = ir;
    PC_M1    = pc_next;
    flush    = fl;
    RESET    = !rst;
    #1;
    stall_exp = must_stall(m_d, m_e);
    check("dof_ready", 128'(dof_ready), 128'(!stall_exp));
    accepted = 1'b0;
    if (rst || fl) begin
      m_d.v = 1'b0;
      m_e.v = 1'b0;
    end else if (stall_exp) begin
      m_e.v = 1'b0;
    end else begin
      if (m_d.v) begin
        exp_q.push_back(expect_issue(m_d, m_e));
        m_e = m_d;
      end else begin
        m_e.v = 1'b0;
      end
      m_d.v    = v;
      m_d.pc   = pc_next;
      m_d.ir   = ir;
      accepted = v;
    end
    if (accepted) pc_next = pc_next + 32'd1;
  endtask

  task automatic issue(input logic [31:0] ir);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 6 && !acc; t++) step(1'b1, ir, 1'b0, 1'b0, acc);
    check("issue_accepted", 128'(acc), 128'(1));
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, 1'b0, acc);
  endtask

  // Monitor: compare every presented bundle against the scoreboard.
  initial begin
    forever begin
      @(negedge CLOCK);
      if (mon_en) begin
        obs = observed();
        if (ex_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_issue: got pc 0x%0h, want no instruction", obs.pc);
          end else begin
            check("issue_bundle", 128'(obs), 128'(exp_q.pop_front()));
          end
        end else begin
          check("bubble_bundle", 128'({ex_valid, obs}), 128'(0));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'd0 : $urandom;
    rf_mem[2] = 32'd5;
    m_d     = '0;
    m_e     = '0;
    pc_next = 32'h0000_0100;

    // Reset with IF presenting: nothing may be captured.
    RESET    = 1'b0;
    if_valid = 1'b1;
    IR       = mk_ir(7'h22, 5'd1, 5'd2, 15'h7FFF);
    PC_M1    = 32'h0000_0040;
    flush    = 1'b0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    check("rst_ex_valid", 128'(ex_valid), 128'(0));
    check("rst_bundle",   128'(observed()), 128'(0));
    check("rst_ready",    128'(dof_ready), 128'(1));
    mon_en = 1'b1;

    // ADI R1,R2,#0x7FFF: zero-filled constant, A from register file (R2 = 5).
    issue(mk_ir(7'h22, 5'd1, 5'd2, 15'h7FFF));
    idle(2);
    // Load-use: one bubble, then ADD reads the register file.
    issue(mk_ir(7'h21, 5'd3, 5'd1, 15'd0));
    issue(mk_ir(7'h02, 5'd4, 5'd3, {5'd5, 10'd0}));
    idle(3);
    // ALU-use: forwarded with DOF_FWD_EN, one bubble otherwise.
    issue(mk_ir(7'h02, 5'd6, 5'd1, {5'd2, 10'd0}));
    issue(mk_ir(7'h02, 5'd7, 5'd6, {5'd6, 10'd0}));
    idle(3);
    // Flush while D is stalled: D, E and the IF instruction are discarded.
    issue(mk_ir(7'h21, 5'd3, 5'd1, 15'd0));
    issue(mk_ir(7'h02, 5'd4, 5'd3, {5'd5, 10'd0}));
    step(1'b1, mk_ir(7'h05, 5'd2, 5'd2, 15'd0), 1'b1, 1'b0, acc);
    idle(2);
    // Writes to R0 never hazard.
    issue(mk_ir(7'h02, 5'd0, 5'd1, {5'd2, 10'd0}));
    issue(mk_ir(7'h02, 5'd9, 5'd0, {5'd0, 10'd0}));
    idle(2);
    // Reset in the middle of a load-use stall; the next cycle must accept.
    issue(mk_ir(7'h21, 5'd3, 5'd1, 15'd0));
    issue(mk_ir(7'h02, 5'd4, 5'd3, {5'd5, 10'd0}));
    step(1'b1, mk_ir(7'h02, 5'd5, 5'd5, 15'd0), 1'b0, 1'b1, acc);
    issue(mk_ir(7'h25, 5'd2, 5'd4, 15'h4001));
    idle(2);
    // Sign-extended negative constant.
    issue(mk_ir(7'h60, 5'd0, 5'd3, 15'h7FF0));
    idle(2);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 85, rand_ir(),
           $urandom_range(0, 99) < 7, $urandom_range(0, 199) == 0, acc);
    end

    idle(4);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
